// File: rtl/latency_tag_arb.sv
// Round-robin issue arbiter with tag allocation and per-tag latency accounting.
// Optional maximum-latency tracking is built when LAT_MAX_TRACK_EN is defined.
module latency_tag_arb #(
  parameter int NREQ = 4,
  parameter int NTAG = 8,
  parameter int W    = 32,
  parameter int TW   = $clog2(NTAG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [TW-1:0]   gnt_tag,
  input  logic            retire,
  input  logic [TW-1:0]   retire_tag,
  input  logic            clear,
  output logic [W-1:0]    issue_cnt_r,
  output logic [W-1:0]    aggregate_cnt_r,
  output logic [TW:0]     outstanding_r,
  output logic            full,
  output logic            err_r,
  output logic [W-1:0]    max_lat_r
);
  localparam int RW = $clog2(NREQ);

  logic [W-1:0]    now;
  logic [NTAG-1:0] busy;
  logic [W-1:0]    ts [NTAG];
  logic [RW-1:0]   rr;

  logic            free_found;
  logic [TW-1:0]   free_tag;
  logic            win_found;
  logic [RW-1:0]   win;
  int              arb_idx;
  logic            grant;
  logic            retire_hit;
  logic [W-1:0]    lat;
  logic [W:0]      agg_sum;

  assign full = (outstanding_r == (TW+1)'(NTAG));

  // Lowest free tag, taken from the registered busy vector so a tag freed
  // this cycle only becomes eligible next cycle.
  always_comb begin
    free_found = 1'b0;
    free_tag   = '0;
    for (int i = NTAG-1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_tag   = TW'(i);
      end
    end
  end

  // Scan from the highest offset down so the lowest offset from rr wins.
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    arb_idx   = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      arb_idx = (int'(rr) + k) % NREQ;
      if (req[arb_idx]) begin
        win_found = 1'b1;
        win       = RW'(arb_idx);
      end
    end
  end

  assign grant      = win_found && free_found && !full && !clear;
  assign gnt        = grant ? (NREQ'(1) << win) : '0;
  assign gnt_tag    = free_tag;
  assign retire_hit = retire && busy[retire_tag] && !clear;
  assign lat        = now - ts[retire_tag];
  assign agg_sum    = {1'b0, aggregate_cnt_r} + {1'b0, lat};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now             <= '0;
      busy            <= '0;
      rr              <= '0;
      issue_cnt_r     <= '0;
      aggregate_cnt_r <= '0;
      outstanding_r   <= '0;
      err_r           <= 1'b0;
    end else begin
      now <= now + 1'b1;
      if (clear) begin
        busy            <= '0;
        rr              <= '0;
        issue_cnt_r     <= '0;
        aggregate_cnt_r <= '0;
        outstanding_r   <= '0;
        err_r           <= 1'b0;
      end else begin
        if (grant) begin
          busy[gnt_tag] <= 1'b1;
          rr            <= (win == RW'(NREQ-1)) ? '0 : win + 1'b1;
          if (issue_cnt_r != '1)
            issue_cnt_r <= issue_cnt_r + 1'b1;
        end
        // A granted tag is always free and a retired one busy, so the two never collide.
        if (retire_hit) begin
          busy[retire_tag] <= 1'b0;
          aggregate_cnt_r  <= agg_sum[W] ? '1 : agg_sum[W-1:0];
        end
        if (retire && !busy[retire_tag])
          err_r <= 1'b1;
        if (grant && !retire_hit)
          outstanding_r <= outstanding_r + 1'b1;
        else if (!grant && retire_hit)
          outstanding_r <= outstanding_r - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant)
      ts[gnt_tag] <= now;
  end

`ifdef LAT_MAX_TRACK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      max_lat_r <= '0;
    else if (clear)
      max_lat_r <= '0;
    else if (retire_hit && (lat > max_lat_r))
      max_lat_r <= lat;
  end
`else
  assign max_lat_r = '0;
`endif

endmodule
